cok_cevrimli_islemci: RTL and testbench
=======================================

Name: cok_cevrimli_islemci

Overview:
- 3-stage multicycle RV32I-subset processor core: fetch, decode/register-read, execute/write-back.
- Each instruction takes exactly 3 clock cycles.
- Talks to a single word-wide main memory (instruction and data) through one address bus with combinational read data and a single write strobe.
- Sits as the CPU next to the main-memory block; the memory is external to this block.

Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.
- ADRES_BIT, 32, memory address width.
- VERI_BIT, 32, data/instruction width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low.
- bellek_adres  output  ADRES_BIT  memory address (byte address).
- bellek_oku_veri  input  VERI_BIT  memory read data, combinationally valid for the current bellek_adres.
- bellek_yaz_veri  output  VERI_BIT  store data.
- bellek_yaz  output  1  store strobe; memory writes bellek_yaz_veri at bellek_adres on the clock edge while high.

Behaviour:
- Internal names, hierarchically visible to benches:
  - simdiki_asama_r: 2-bit stage register.
  - Localparams GETIR=2'd0, COZYAZMACOKU=2'd1, YURUTGERIYAZ=2'd2.
  - yazmac_obegi[0:31]: 32x32 register file.
- Reset (rst==0 at a rising edge): PC<=RESET_PC, simdiki_asama_r<=GETIR.
  - While in reset: bellek_yaz=0, bellek_adres=PC.
  - The register file is NOT cleared; contents preloaded by a bench survive reset.
  - Reset mid-instruction aborts that instruction with no register or memory side effect.
- Stage sequence: GETIR -> COZYAZMACOKU -> YURUTGERIYAZ -> GETIR. No stalls; state 2'd3 returns to GETIR.
- GETIR:
  - bellek_adres=PC.
  - Instruction register latches bellek_oku_veri at the end of the cycle.
- COZYAZMACOKU:
  - Decode opcode/funct3/funct7 and generate the immediate (I/S/B/U/J, sign-extended).
  - Latch rs1/rs2 values; x0 always reads 0.
  - bellek_adres=PC, bellek_yaz=0.
- YURUTGERIYAZ: ALU/branch/memory; rd written and PC updated at the end of the cycle.
  - OP/OP-IMM: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND and the immediate forms. Shift amount is the low 5 bits. Arithmetic wraps mod 2^32.
  - LUI: rd=imm. AUIPC: rd=PC+imm.
  - JAL: rd=PC+4; PC=PC+imm.
  - JALR: rd=PC+4; PC=(rs1+imm)&~1, using the old rs1 value even when rd==rs1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: if taken, PC=PC+imm (B-imm, bit0=0); else PC+4.
  - LW: bellek_adres=rs1+imm; rd=bellek_oku_veri.
  - SW: bellek_adres=rs1+imm; bellek_yaz_veri=rs2; bellek_yaz=1 this cycle only.
  - All other opcodes execute as NOP: PC+4, no writes.
- Writes to x0 are discarded.
- bellek_yaz is 0 in every stage except the SW execute cycle.

Test Plan:
- Preload x1=0xfff, x2=-0xfff; [0x8000_0000]=beq x1,x2,1024 (0x40208063); release reset -> stages GETIR,COZYAZMACOKU,YURUTGERIYAZ one per cycle; next GETIR bellek_adres=0x8000_0004.
- x1=x3=0xfff; nop at 0x8000_0000, beq x1,x3,16 (0x00308863) at 0x8000_0004 -> after 2 instructions bellek_adres=0x8000_0014.
- 4 nops then beq x1,x3,-4 (0xfe308ee3) at 0x8000_0010 -> after 5 instructions bellek_adres=0x8000_000C.
- jal x5,512 (0x200002ef) at RESET_PC -> next fetch 0x8000_0200, x5=0x8000_0004.
- x4=0x8000_1200; jalr x5,512(x4) (0x200202e7) -> next fetch 0x8000_1400, x5=0x8000_0004.
- addi x6,x0,0x55; sw x6,0(x4); lw x7,0(x4) -> bellek_yaz high exactly one cycle; x7=0x55. Reset asserted mid-instruction -> PC=0x8000_0000, registers unchanged.

Source files
------------

// File: rtl/cok_cevrimli_islemci.sv
// Multicycle RV32I-subset core: fetch, decode/register read, then execute and write back.
// Every instruction takes exactly three cycles. One shared word-wide memory port serves
// both instruction fetch and data access.
module cok_cevrimli_islemci #(
  parameter int                 ADRES_BIT = 32,
  parameter int                 VERI_BIT  = 32,
  parameter logic [ADRES_BIT-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [ADRES_BIT-1:0] bellek_adres,
  input  logic [VERI_BIT-1:0]  bellek_oku_veri,
  output logic [VERI_BIT-1:0]  bellek_yaz_veri,
  output logic                 bellek_yaz
);

  localparam logic [1:0] GETIR        = 2'd0;
  localparam logic [1:0] COZYAZMACOKU = 2'd1;
  localparam logic [1:0] YURUTGERIYAZ = 2'd2;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  logic [1:0]           simdiki_asama_r, sonraki_asama;
  logic [ADRES_BIT-1:0] pc_r, sonraki_pc;
  logic [VERI_BIT-1:0]  buyruk_r;
  logic [VERI_BIT-1:0]  kaynak1_r, kaynak2_r, anlik_r;
  logic [VERI_BIT-1:0]  yazmac_obegi [0:31];

  // instruction fields, always taken from the latched instruction
  logic [6:0] opkod;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opkod = buyruk_r[6:0];
  assign f3    = buyruk_r[14:12];
  assign rd    = buyruk_r[11:7];
  assign rs1   = buyruk_r[19:15];
  assign rs2   = buyruk_r[24:20];

  // immediate generation, sign-extended per instruction format
  logic [VERI_BIT-1:0] anlik;
  always_comb begin
    anlik = '0;
    case (opkod)
      OP_IMM, OP_LOAD, OP_JALR: anlik = {{20{buyruk_r[31]}}, buyruk_r[31:20]};
      OP_STORE:  anlik = {{20{buyruk_r[31]}}, buyruk_r[31:25], buyruk_r[11:7]};
      OP_BRANCH: anlik = {{19{buyruk_r[31]}}, buyruk_r[31], buyruk_r[7],
                          buyruk_r[30:25], buyruk_r[11:8], 1'b0};
      OP_LUI, OP_AUIPC: anlik = {buyruk_r[31:12], 12'b0};
      OP_JAL:    anlik = {{11{buyruk_r[31]}}, buyruk_r[31], buyruk_r[19:12],
                          buyruk_r[20], buyruk_r[30:21], 1'b0};
      default:   anlik = '0;
    endcase
  end

  // ALU; second operand is rs2 for OP, the immediate otherwise
  logic [VERI_BIT-1:0] alu_b, alu_sonuc, etkin_adres;
  logic [4:0]          kayma;
  logic                cikar, aritmetik;
  assign alu_b       = (opkod == OP_OP) ? kaynak2_r : anlik_r;
  assign kayma       = alu_b[4:0];
  assign cikar       = (opkod == OP_OP) && buyruk_r[30];
  assign aritmetik   = buyruk_r[30];
  assign etkin_adres = kaynak1_r + anlik_r;

  always_comb begin
    alu_sonuc = '0;
    case (f3)
      3'd0: alu_sonuc = cikar ? kaynak1_r - alu_b : kaynak1_r + alu_b;
      3'd1: alu_sonuc = kaynak1_r << kayma;
      3'd2: alu_sonuc = {31'b0, $signed(kaynak1_r) < $signed(alu_b)};
      3'd3: alu_sonuc = {31'b0, kaynak1_r < alu_b};
      3'd4: alu_sonuc = kaynak1_r ^ alu_b;
      3'd5: alu_sonuc = aritmetik ? VERI_BIT'($signed(kaynak1_r) >>> kayma)
                                  : kaynak1_r >> kayma;
      3'd6: alu_sonuc = kaynak1_r | alu_b;
      default: alu_sonuc = kaynak1_r & alu_b;
    endcase
  end

  // branch condition from funct3
  logic dallan;
  always_comb begin
    dallan = 1'b0;
    case (f3)
      3'd0: dallan = (kaynak1_r == kaynak2_r);
      3'd1: dallan = (kaynak1_r != kaynak2_r);
      3'd4: dallan = ($signed(kaynak1_r) <  $signed(kaynak2_r));
      3'd5: dallan = ($signed(kaynak1_r) >= $signed(kaynak2_r));
      3'd6: dallan = (kaynak1_r <  kaynak2_r);
      3'd7: dallan = (kaynak1_r >= kaynak2_r);
      default: dallan = 1'b0;
    endcase
  end

  // execute-stage results: next PC and register write-back
  logic                yaz_en;
  logic [VERI_BIT-1:0] yaz_veri;
  always_comb begin
    sonraki_pc = pc_r + 4;
    yaz_en     = 1'b0;
    yaz_veri   = '0;
    case (opkod)
      OP_OP, OP_IMM: begin yaz_en = 1'b1; yaz_veri = alu_sonuc; end
      OP_LUI:        begin yaz_en = 1'b1; yaz_veri = anlik_r; end
      OP_AUIPC:      begin yaz_en = 1'b1; yaz_veri = pc_r + anlik_r; end
      OP_JAL: begin
        yaz_en = 1'b1; yaz_veri = pc_r + 4; sonraki_pc = pc_r + anlik_r;
      end
      OP_JALR: begin
        // kaynak1_r was latched a cycle earlier, so rd==rs1 still sees the old value
        yaz_en = 1'b1; yaz_veri = pc_r + 4; sonraki_pc = etkin_adres & ~32'd1;
      end
      OP_BRANCH: if (dallan) sonraki_pc = pc_r + anlik_r;
      OP_LOAD:   begin yaz_en = 1'b1; yaz_veri = bellek_oku_veri; end
      default: ;
    endcase
  end

  // stage register
  always_ff @(posedge clk) begin
    if (!rst) simdiki_asama_r <= GETIR;
    else      simdiki_asama_r <= sonraki_asama;
  end

  // fixed stage rotation; the unused encoding falls back to fetch
  always_comb begin
    case (simdiki_asama_r)
      GETIR:        sonraki_asama = COZYAZMACOKU;
      COZYAZMACOKU: sonraki_asama = YURUTGERIYAZ;
      default:      sonraki_asama = GETIR;
    endcase
  end

  // memory port: PC except for the load/store execute cycle; strobe only on store execute
  always_comb begin
    bellek_adres    = pc_r;
    bellek_yaz      = 1'b0;
    bellek_yaz_veri = kaynak2_r;
    if (rst && simdiki_asama_r == YURUTGERIYAZ) begin
      if (opkod == OP_LOAD || opkod == OP_STORE) bellek_adres = etkin_adres;
      if (opkod == OP_STORE) bellek_yaz = 1'b1;
    end
  end

  // datapath registers: instruction latch, operand latch, PC update
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r <= RESET_PC;
    end else begin
      case (simdiki_asama_r)
        GETIR: buyruk_r <= bellek_oku_veri;
        COZYAZMACOKU: begin
          kaynak1_r <= (rs1 == 5'd0) ? '0 : yazmac_obegi[rs1];
          kaynak2_r <= (rs2 == 5'd0) ? '0 : yazmac_obegi[rs2];
          anlik_r   <= anlik;
        end
        YURUTGERIYAZ: pc_r <= sonraki_pc;
        default: ;
      endcase
    end
  end

  // register file write; not cleared by reset, x0 writes dropped
  always_ff @(posedge clk) begin
    if (rst && simdiki_asama_r == YURUTGERIYAZ && yaz_en && rd != 5'd0)
      yazmac_obegi[rd] <= yaz_veri;
  end

endmodule

// File: tb/tb_cok_cevrimli_islemci.sv
// Bench for cok_cevrimli_islemci: behavioural memory, hand-encoded programs,
// expected register/address values queued at load time and checked after the run.
module tb_cok_cevrimli_islemci;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bellek_adres, bellek_oku_veri, bellek_yaz_veri;
  logic        bellek_yaz;

  localparam int ADRES = 32;  // scoreboard index meaning "bellek_adres"

  cok_cevrimli_islemci dut (
    .clk(clk), .rst(rst),
    .bellek_adres(bellek_adres), .bellek_oku_veri(bellek_oku_veri),
    .bellek_yaz_veri(bellek_yaz_veri), .bellek_yaz(bellek_yaz)
  );

  always #5 clk = ~clk;

  // program region below 0x8000_1000, data region above; stores land only in data region
  logic [31:0] prog_mem [0:1023];
  logic [31:0] veri_mem [0:1023] = '{default: 32'h0};
  assign bellek_oku_veri = bellek_adres[12] ? veri_mem[bellek_adres[11:2]]
                                            : prog_mem[bellek_adres[11:2]];
  always @(posedge clk)
    if (bellek_yaz) veri_mem[bellek_adres[11:2]] <= bellek_yaz_veri;

  typedef struct {
    string       tag;
    int          idx;
    logic [31:0] val;
  } bekle_t;
  bekle_t beklenen_q[$];

  int n_kars = 0;
  int n_hata = 0;

  task automatic kontrol(input string tag, input logic [31:0] gozlenen, input logic [31:0] beklenen);
    n_kars++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: got %h expected %h", tag, gozlenen, beklenen);
    end
  endtask

  function automatic logic [31:0] gozle(input int idx);
    if (idx == ADRES) return bellek_adres;
    return dut.yazmac_obegi[idx];
  endfunction

  task automatic bekle(input string tag, input int idx, input logic [31:0] val);
    bekle_t b;
    b.tag = tag; b.idx = idx; b.val = val;
    beklenen_q.push_back(b);
  endtask

  task automatic bosalt();
    bekle_t b;
    while (beklenen_q.size() > 0) begin
      b = beklenen_q.pop_front();
      kontrol(b.tag, gozle(b.idx), b.val);
    end
  endtask

  // hold reset, wipe program memory; registers are preloaded afterwards by the caller
  task automatic sifirla();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) prog_mem[i] = 32'h0000_0013;
    @(negedge clk);
  endtask

  // release reset and let n instructions complete; ends at the negedge of the next fetch
  task automatic calistir(input int n);
    rst = 1'b1;
    repeat (3 * n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int yaz_say;

    // not-taken beq, stage walk
    sifirla();
    dut.yazmac_obegi[1] = 32'h0000_0fff;
    dut.yazmac_obegi[2] = 32'hffff_f001;
    prog_mem[0] = 32'h4020_8063;
    @(negedge clk);
    kontrol("rst_asama", {30'b0, dut.simdiki_asama_r}, 32'd0);
    kontrol("rst_adres", bellek_adres, 32'h8000_0000);
    kontrol("rst_yaz", {31'b0, bellek_yaz}, 32'd0);
    rst = 1'b1;
    kontrol("asama0", {30'b0, dut.simdiki_asama_r}, 32'd0);
    @(negedge clk);
    kontrol("asama1", {30'b0, dut.simdiki_asama_r}, 32'd1);
    @(negedge clk);
    kontrol("asama2", {30'b0, dut.simdiki_asama_r}, 32'd2);
    @(negedge clk);
    kontrol("asama3", {30'b0, dut.simdiki_asama_r}, 32'd0);
    kontrol("beq_alinmadi", bellek_adres, 32'h8000_0004);

    // taken forward beq
    sifirla();
    dut.yazmac_obegi[1] = 32'h0000_0fff;
    dut.yazmac_obegi[3] = 32'h0000_0fff;
    prog_mem[1] = 32'h0030_8863;
    bekle("beq_ileri", ADRES, 32'h8000_0014);
    calistir(2);
    bosalt();

    // taken backward beq
    sifirla();
    prog_mem[4] = 32'hfe30_8ee3;
    bekle("beq_geri", ADRES, 32'h8000_000c);
    calistir(5);
    bosalt();

    // jal
    sifirla();
    prog_mem[0] = 32'h2000_02ef;
    bekle("jal_pc", ADRES, 32'h8000_0200);
    bekle("jal_rd", 5, 32'h8000_0004);
    calistir(1);
    bosalt();

    // jalr
    sifirla();
    dut.yazmac_obegi[4] = 32'h8000_1200;
    dut.yazmac_obegi[5] = 32'h0;
    prog_mem[0] = 32'h2002_02e7;
    bekle("jalr_pc", ADRES, 32'h8000_1400);
    bekle("jalr_rd", 5, 32'h8000_0004);
    calistir(1);
    bosalt();

    // ALU, lui/auipc, taken blt skipping one instruction
    sifirla();
    dut.yazmac_obegi[1]  = 32'h0000_0fff;
    dut.yazmac_obegi[2]  = 32'hffff_f001;
    dut.yazmac_obegi[20] = 32'h0;
    prog_mem[0]  = 32'h0020_8533; bekle("add",   10, 32'h0000_0000);
    prog_mem[1]  = 32'h4020_85b3; bekle("sub",   11, 32'h0000_1ffe);
    prog_mem[2]  = 32'h0011_2633; bekle("slt",   12, 32'h0000_0001);
    prog_mem[3]  = 32'h0011_36b3; bekle("sltu",  13, 32'h0000_0000);
    prog_mem[4]  = 32'h4011_5733; bekle("sra",   14, 32'hffff_ffff);
    prog_mem[5]  = 32'h0011_57b3; bekle("srl",   15, 32'h0000_0001);
    prog_mem[6]  = 32'h0020_c833; bekle("xor",   16, 32'hffff_fffe);
    prog_mem[7]  = 32'h1234_58b7; bekle("lui",   17, 32'h1234_5000);
    prog_mem[8]  = 32'h0000_1917; bekle("auipc", 18, 32'h8000_1020);
    prog_mem[9]  = 32'h0040_9993; bekle("slli",  19, 32'h0000_fff0);
    prog_mem[10] = 32'h0011_4463;
    prog_mem[11] = 32'h0010_0a13; bekle("blt_atla", 20, 32'h0000_0000);
    prog_mem[12] = 32'h0ff1_7a93; bekle("andi",  21, 32'h0000_0001);
    bekle("alu_pc", ADRES, 32'h8000_0034);
    calistir(12);
    bosalt();

    // store then load, single-cycle write strobe
    sifirla();
    dut.yazmac_obegi[4] = 32'h8000_1200;
    dut.yazmac_obegi[7] = 32'h0;
    prog_mem[0] = 32'h0550_0313;
    prog_mem[1] = 32'h0062_2023;
    prog_mem[2] = 32'h0002_2383;
    bekle("addi", 6, 32'h0000_0055);
    bekle("lw", 7, 32'h0000_0055);
    rst = 1'b1;
    yaz_say = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (bellek_yaz) yaz_say++;
    end
    kontrol("yaz_sayisi", yaz_say, 32'd1);
    kontrol("sw_bellek", veri_mem[10'h080], 32'h0000_0055);
    bosalt();

    // reset during execute aborts the instruction
    sifirla();
    dut.yazmac_obegi[8] = 32'h0000_1234;
    prog_mem[0] = 32'h0770_0413;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    kontrol("orta_asama", {30'b0, dut.simdiki_asama_r}, 32'd2);
    rst = 1'b0;
    @(negedge clk);
    bekle("orta_adres", ADRES, 32'h8000_0000);
    bekle("orta_x8", 8, 32'h0000_1234);
    bekle("orta_x7", 7, 32'h0000_0055);
    kontrol("orta_rst_asama", {30'b0, dut.simdiki_asama_r}, 32'd0);
    bosalt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_kars, n_hata);
    $finish;
  end

endmodule
